// File: rtl/divider_restoring.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero bypasses the iteration and reports all-ones quotient with rem = A.
module divider_restoring #(
    parameter int bw = 16
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          start,
    input  logic [bw-1:0] A,
    input  logic [bw-1:0] B,
    output logic [bw-1:0] quot,
    output logic [bw-1:0] rem,
    output logic          busy,
    output logic          done,
    output logic          div_zero
);

    localparam int CW = $clog2(bw + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t        state;
    logic [bw-1:0] part;       // partial remainder, always < divisor so bw bits suffice
    logic [bw-1:0] dvd;        // dividend bits shift out as quotient bits shift in
    logic [bw-1:0] dvs;
    logic [CW-1:0] cnt;

    logic [bw:0]   shifted;
    logic [bw:0]   diff;
    logic          ge;
    logic [bw:0]   part_next;
    logic [bw-1:0] dvd_next;
    logic          unused_part_msb;

    always_comb begin
        shifted         = {part, dvd[bw-1]};
        diff            = shifted - {1'b0, dvs};
        ge              = shifted >= {1'b0, dvs};
        part_next       = ge ? diff : shifted;
        dvd_next        = {dvd[bw-2:0], ge};
        unused_part_msb = part_next[bw];
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= StIdle;
            part     <= '0;
            dvd      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            quot     <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                    if (start) begin
                        if (B == '0) begin
                            quot     <= '1;
                            rem      <= A;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= StDone;
                        end else begin
                            dvd   <= A;
                            dvs   <= B;
                            part  <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= StRun;
                        end
                    end
                end
                StRun: begin
                    part <= part_next[bw-1:0];
                    dvd  <= dvd_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(bw - 1)) begin
                        quot     <= dvd_next;
                        rem      <= part_next[bw-1:0];
                        div_zero <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cnt      <= '0;
                        state    <= StDone;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/divider_restoring.md
DIVIDER_RESTORING -- requirements
Module: divider_restoring

Interface
REQ-001 The block SHALL have one parameter: bw, default 16, operand and result width in bits.
REQ-002 The block SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request to begin a division; sampled on the CLK rising edge.
REQ-005 The block SHALL have port A  input  bw  unsigned dividend; sampled only on the edge that accepts start.
REQ-006 The block SHALL have port B  input  bw  unsigned divisor; sampled only on the edge that accepts start.
REQ-007 The block SHALL have port quot  output  bw  registered unsigned quotient.
REQ-008 The block SHALL have port rem  output  bw  registered unsigned remainder.
REQ-009 The block SHALL have port busy  output  1  high while a division is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse when quot and rem become valid.
REQ-011 The block SHALL have port div_zero  output  1  high with the results when the latched divisor was 0.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-013 The block SHALL accept start only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on operands, counter or outputs.
REQ-014 On the accepting edge (edge k) with B != 0, the block SHALL latch A and B, clear the partial remainder, clear the iteration counter and enter RUN; busy SHALL be 1 from edge k.
REQ-015 In RUN, each edge SHALL perform one restoring step MSB-first: shift {remainder, dividend} left 1; if the shifted remainder >= divisor, subtract the divisor and set the quotient LSB to 1, else set it to 0.
REQ-016 The remainder/compare path SHALL be bw+1 bits wide so that no compare or subtract overflows for any bw-bit operands.
REQ-017 After exactly bw RUN steps (edges k+1..k+bw), at edge k+bw the block SHALL load quot and rem, set done=1, clear busy and enter DONE.
REQ-018 Total latency SHALL be bw cycles from the accepting edge to done high, i.e. 16 cycles for bw=16.
REQ-019 The block SHALL hold done high for exactly one cycle; from DONE it SHALL return to IDLE on the next edge unless start is accepted there.
REQ-020 A start accepted in DONE SHALL behave as in REQ-014; done SHALL fall on that edge (back-to-back operation, no idle cycle required).
REQ-021 quot, rem and div_zero SHALL hold their values until the next completion, including while a new division is in RUN.
REQ-022 If B == 0 on the accepting edge, the block SHALL skip RUN, enter DONE on that edge with quot = all ones, rem = A, div_zero = 1 and done = 1 one cycle later than the accept, and busy SHALL stay 0.
REQ-023 For B != 0, results SHALL satisfy A == quot*B + rem with rem < B, and div_zero SHALL be 0.
REQ-024 The iteration counter SHALL be ceil(log2(bw+1)) bits and SHALL not wrap during RUN.

Reset
REQ-025 On RESETn low, the block SHALL immediately, independent of CLK, set the FSM to IDLE and set quot=0, rem=0, busy=0, done=0, div_zero=0 and the counter and internal registers to 0.
REQ-026 A reset asserted mid-RUN SHALL abort the division; after release, no done pulse SHALL appear until a new start is accepted.
REQ-027 On the first CLK edge after RESETn rises, the block SHALL accept start if it is high.

Verification
REQ-028 Bench: bw=16, A=100, B=7, start pulse -> busy for 16 cycles, done at accept+16, quot=14, rem=2, div_zero=0.
REQ-029 Bench: A=0xFFFF, B=1 -> quot=0xFFFF, rem=0; then A=5, B=9 -> quot=0, rem=5.
REQ-030 Bench: A=1234, B=0 -> done one cycle after accept, busy never high, quot=0xFFFF, rem=1234, div_zero=1.
REQ-031 Bench: start held high across RUN with changing A/B -> result matches the operands latched at the accepting edge only; start held in DONE -> next division begins immediately.
REQ-032 Bench: RESETn pulsed low at accept+5 -> all outputs 0 asynchronously, no done afterward until a new start.
REQ-033 Bench: 10,000 random (A,B) pairs, back-to-back -> every result satisfies REQ-022/REQ-023 against a reference model.
